// File: rtl/gcd_operand_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : gcd_operand_sequencer
// Purpose  : Front-end stage for the GCD controller/datapath pair. Accepts an
//            operand pair over valid/ready, drives operand A then B onto the
//            core's shared data bus with a start pulse, waits for core_done,
//            and captures the result into a 1-deep output buffer. It then
//            holds core_clr to return the core to its load state. Zero
//            operands are resolved locally, because a subtractive GCD core
//            never terminates on a zero operand.
// Ports    : clk, rst (sync, active-high)
//            in_valid/in_ready/in_a/in_b        operand pair handshake
//            res_valid/res_ready/res_gcd/res_err result buffer handshake
//            core_start/core_data/core_clr      drive to GCD core
//            core_done/core_result              status from GCD core
//            busy                               high in any non-IDLE state
// Config   : define GCD_SEQ_TIMEOUT_EN to abort WAIT after TIMEOUT cycles
//            without core_done (result reported as res_err=1, res_gcd=0).
// Revision : 1.0 - initial release
// ============================================================================
module gcd_operand_sequencer #(
    parameter int WIDTH      = 16,
    parameter int CLR_CYCLES = 2,
    parameter int TIMEOUT    = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_gcd,
    output logic             res_err,
    output logic             core_start,
    output logic [WIDTH-1:0] core_data,
    output logic             core_clr,
    input  logic             core_done,
    input  logic [WIDTH-1:0] core_result,
    output logic             busy
);

    localparam logic [2:0] c_S_IDLE    = 3'd0;
    localparam logic [2:0] c_S_ZCHK    = 3'd1;
    localparam logic [2:0] c_S_ISSUE_A = 3'd2;
    localparam logic [2:0] c_S_ISSUE_B = 3'd3;
    localparam logic [2:0] c_S_WAIT    = 3'd4;
    localparam logic [2:0] c_S_CAPTURE = 3'd5;
    localparam logic [2:0] c_S_CLEAR   = 3'd6;

    // The clear counter counts down from CLR_CYCLES-1 to 0, so it only
    // needs to represent CLR_CYCLES-1.
    localparam int              c_CW       = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
    localparam logic [c_CW-1:0] c_CLR_LOAD = c_CW'(CLR_CYCLES - 1);

    logic [2:0]       r_state;
    logic [c_CW-1:0]  r_clr_cnt;
    logic [WIDTH-1:0] r_op_a;
    logic [WIDTH-1:0] r_op_b;
    logic             r_res_valid;
    logic [WIDTH-1:0] r_res_gcd;
    logic             r_res_err;
    logic             r_core_start;
    logic [WIDTH-1:0] r_core_data;
    logic             r_core_clr;
    logic             w_in_ready;
    logic             w_a_zero;
    logic             w_b_zero;

`ifdef GCD_SEQ_TIMEOUT_EN
    localparam int              c_TW      = $clog2(TIMEOUT + 1);
    localparam logic [c_TW-1:0] c_TO_LAST = c_TW'(TIMEOUT - 1);
    logic [c_TW-1:0] r_wait_cnt;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT > 0);
`endif

    // A full result buffer blocks new work, so a result is never overwritten.
    assign w_in_ready = (r_state == c_S_IDLE) && !r_res_valid;
    assign w_a_zero   = (r_op_a == '0);
    assign w_b_zero   = (r_op_b == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            // Reset leaves the core in its load state via the CLEAR sequence.
            r_state      <= c_S_CLEAR;
            r_clr_cnt    <= c_CLR_LOAD;
            r_core_clr   <= 1'b1;
            r_core_start <= 1'b0;
            r_core_data  <= '0;
            r_res_valid  <= 1'b0;
            r_res_gcd    <= '0;
            r_res_err    <= 1'b0;
            r_op_a       <= '0;
            r_op_b       <= '0;
`ifdef GCD_SEQ_TIMEOUT_EN
            r_wait_cnt   <= '0;
`endif
        end else begin
            // Every set of r_res_valid below happens with the buffer empty,
            // so this drain never collides with a new result.
            if (r_res_valid && res_ready) begin
                r_res_valid <= 1'b0;
            end

            case (r_state)
                c_S_IDLE: begin
                    if (in_valid && w_in_ready) begin
                        r_op_a  <= in_a;
                        r_op_b  <= in_b;
                        r_state <= c_S_ZCHK;
                    end
                end

                c_S_ZCHK: begin
                    if (w_a_zero || w_b_zero) begin
                        // gcd(0,x)=x and gcd(x,0)=x; 0/0 is undefined.
                        r_res_gcd   <= w_a_zero ? r_op_b : r_op_a;
                        r_res_err   <= w_a_zero && w_b_zero;
                        r_res_valid <= 1'b1;
                        r_state     <= c_S_IDLE;
                    end else begin
                        r_core_data  <= r_op_a;
                        r_core_start <= 1'b1;
                        r_state      <= c_S_ISSUE_A;
                    end
                end

                c_S_ISSUE_A: begin
                    r_core_data  <= r_op_b;
                    r_core_start <= 1'b0;
                    r_state      <= c_S_ISSUE_B;
                end

                c_S_ISSUE_B: begin
                    r_state    <= c_S_WAIT;
`ifdef GCD_SEQ_TIMEOUT_EN
                    r_wait_cnt <= '0;
`endif
                end

                c_S_WAIT: begin
                    // core_done takes priority over an expiring timeout.
                    if (core_done) begin
                        r_state <= c_S_CAPTURE;
                    end
`ifdef GCD_SEQ_TIMEOUT_EN
                    else if (r_wait_cnt == c_TO_LAST) begin
                        r_res_gcd   <= '0;
                        r_res_err   <= 1'b1;
                        r_res_valid <= 1'b1;
                        r_core_clr  <= 1'b1;
                        r_clr_cnt   <= c_CLR_LOAD;
                        r_state     <= c_S_CLEAR;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
`endif
                end

                c_S_CAPTURE: begin
                    // core_result is still valid: core_done is sticky until core_clr.
                    r_res_gcd   <= core_result;
                    r_res_err   <= 1'b0;
                    r_res_valid <= 1'b1;
                    r_core_clr  <= 1'b1;
                    r_clr_cnt   <= c_CLR_LOAD;
                    r_state     <= c_S_CLEAR;
                end

                c_S_CLEAR: begin
                    if (r_clr_cnt == '0) begin
                        r_core_clr <= 1'b0;
                        r_state    <= c_S_IDLE;
                    end else begin
                        r_clr_cnt <= r_clr_cnt - 1'b1;
                    end
                end

                default: begin
                    r_core_start <= 1'b0;
                    r_core_clr   <= 1'b1;
                    r_clr_cnt    <= c_CLR_LOAD;
                    r_state      <= c_S_CLEAR;
                end
            endcase
        end
    end

    assign in_ready   = w_in_ready;
    assign busy       = (r_state != c_S_IDLE);
    assign res_valid  = r_res_valid;
    assign res_gcd    = r_res_gcd;
    assign res_err    = r_res_err;
    assign core_start = r_core_start;
    assign core_data  = r_core_data;
    assign core_clr   = r_core_clr;

endmodule
`default_nettype wire

// File: tb/tb_gcd_operand_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_gcd_operand_sequencer
// Purpose  : Self-checking bench for gcd_operand_sequencer with a behavioural
//            GCD core model and a Euclid-based reference for results.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gcd_operand_sequencer;

    localparam int WIDTH      = 16;
    localparam int CLR_CYCLES = 2;
    localparam int TB_TIMEOUT = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_a = '0;
    logic [WIDTH-1:0] in_b = '0;
    logic             res_valid;
    logic             res_ready = 1'b0;
    logic [WIDTH-1:0] res_gcd;
    logic             res_err;
    logic             core_start;
    logic [WIDTH-1:0] core_data;
    logic             core_clr;
    logic             core_done;
    logic [WIDTH-1:0] core_result;
    logic             busy;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    gcd_operand_sequencer #(
        .WIDTH      (WIDTH),
        .CLR_CYCLES (CLR_CYCLES),
        .TIMEOUT    (TB_TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_gcd     (res_gcd),
        .res_err     (res_err),
        .core_start  (core_start),
        .core_data   (core_data),
        .core_clr    (core_clr),
        .core_done   (core_done),
        .core_result (core_result),
        .busy        (busy)
    );

    // Reference GCD by Euclid's remainder method.
    function automatic int unsigned ref_gcd(input int unsigned a, input int unsigned b);
        int unsigned x = a;
        int unsigned y = b;
        int unsigned t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Behavioural core: latches A on start, B on the next cycle, then raises
    // a sticky done core_delay cycles after B was on the bus.
    int               core_delay  = 6;
    bit               core_never  = 1'b0;
    int               core_phase  = 0;
    int               core_cnt    = 0;
    int               start_pulses = 0;
    logic [WIDTH-1:0] core_opa = '0;
    logic [WIDTH-1:0] core_opb = '0;

    always @(posedge clk) begin
        if (core_start === 1'b1) start_pulses <= start_pulses + 1;
        if (rst || core_clr === 1'b1) begin
            core_phase  <= 0;
            core_done   <= 1'b0;
            core_result <= '0;
        end else begin
            case (core_phase)
                0: if (core_start === 1'b1) begin
                    core_opa   <= core_data;
                    core_phase <= 1;
                end
                1: begin
                    core_opb <= core_data;
                    if (!core_never && core_delay <= 1) begin
                        core_done   <= 1'b1;
                        core_result <= WIDTH'(ref_gcd(core_opa, core_data));
                        core_phase  <= 3;
                    end else begin
                        core_cnt   <= 2;
                        core_phase <= 2;
                    end
                end
                2: if (!core_never && core_cnt >= core_delay) begin
                    core_done   <= 1'b1;
                    core_result <= WIDTH'(ref_gcd(core_opa, core_opb));
                    core_phase  <= 3;
                end else begin
                    core_cnt <= core_cnt + 1;
                end
                default: ;
            endcase
        end
    end

    // Present a pair and wait for the accept edge; returns #1 after it.
    task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        int guard = 0;
        in_a = a; in_b = b; in_valid = 1'b1;
        while (in_ready !== 1'b1 && guard < 200) begin
            @(posedge clk); #1; guard++;
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL accept_wait: in_ready=%b required 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Wait for the result of an accepted pair and check it against the model.
    task automatic collect(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input int d, input bit timed_out, input int sp0, input string tag);
        int lat = 1;
        int n   = 0;
        bit zero = (a == 0) || (b == 0);
        int exp_lat;
        logic [WIDTH-1:0] exp_gcd;
        logic exp_err;
        exp_lat = zero ? 2 : (timed_out ? 4 + TB_TIMEOUT : 5 + d);
        exp_gcd = timed_out ? '0 : WIDTH'(ref_gcd(a, b));
        exp_err = timed_out || (a == 0 && b == 0);
        while (res_valid !== 1'b1 && lat < 400) begin
            @(posedge clk); #1; lat++;
        end
        n_cmp++;
        if (lat !== exp_lat) begin
            n_fail++;
            $display("FAIL %s latency: got %0d required %0d", tag, lat, exp_lat);
        end
        n_cmp++;
        if (res_gcd !== exp_gcd) begin
            n_fail++;
            $display("FAIL %s res_gcd: got %0d required %0d", tag, res_gcd, exp_gcd);
        end
        n_cmp++;
        if (res_err !== exp_err) begin
            n_fail++;
            $display("FAIL %s res_err: got %b required %b", tag, res_err, exp_err);
        end
        n_cmp++;
        if (start_pulses - sp0 !== (zero ? 0 : 1)) begin
            n_fail++;
            $display("FAIL %s start_pulses: got %0d required %0d", tag, start_pulses - sp0, zero ? 0 : 1);
        end
        if (!zero) begin
            n_cmp++;
            if (core_opa !== a || core_opb !== b) begin
                n_fail++;
                $display("FAIL %s core_bus: got A=%0d B=%0d required A=%0d B=%0d", tag, core_opa, core_opb, a, b);
            end
        end
        while (core_clr === 1'b1 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        n_cmp++;
        if (n !== (zero ? 0 : CLR_CYCLES)) begin
            n_fail++;
            $display("FAIL %s core_clr_cycles: got %0d required %0d", tag, n, zero ? 0 : CLR_CYCLES);
        end
        n_cmp++;
        if (busy !== 1'b0 || in_ready !== 1'b0 || res_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL %s held_result: busy=%b in_ready=%b res_valid=%b required 0 0 1", tag, busy, in_ready, res_valid);
        end
    endtask

    task automatic drain(input string tag);
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        n_cmp++;
        if (res_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s drain: res_valid=%b in_ready=%b required 0 1", tag, res_valid, in_ready);
        end
    endtask

    // Returns once core_clr has been low-sampled; checks its run length.
    task automatic check_clear_run(input string tag);
        int n = 0;
        while (core_clr === 1'b1 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        n_cmp++;
        if (n !== CLR_CYCLES) begin
            n_fail++;
            $display("FAIL %s clr_cycles: got %0d required %0d", tag, n, CLR_CYCLES);
        end
        n_cmp++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s idle_after_clear: in_ready=%b busy=%b required 1 0", tag, in_ready, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (in_ready !== 1'b0 || res_valid !== 1'b0 || core_clr !== 1'b1 || core_start !== 1'b0 ||
            core_data !== '0 || res_gcd !== '0 || res_err !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_values: in_ready=%b res_valid=%b core_clr=%b core_start=%b core_data=%0d res_gcd=%0d res_err=%b busy=%b required 0 0 1 0 0 0 0 1",
                     in_ready, res_valid, core_clr, core_start, core_data, res_gcd, res_err, busy);
        end
        rst = 1'b0;
        check_clear_run("reset");
    endtask

    task automatic test_basic();
        int sp0;
        core_delay = 6;
        sp0 = start_pulses;
        issue(16'd48, 16'd18);
        collect(16'd48, 16'd18, 6, 1'b0, sp0, "basic_48_18");
        drain("basic_48_18");
    endtask

    task automatic test_zero_operands();
        logic [WIDTH-1:0] za [3] = '{16'd0, 16'd0, 16'd21};
        logic [WIDTH-1:0] zb [3] = '{16'd35, 16'd0, 16'd0};
        int sp0;
        for (int i = 0; i < 3; i++) begin
            sp0 = start_pulses;
            issue(za[i], zb[i]);
            collect(za[i], zb[i], 1, 1'b0, sp0, "zero_op");
            drain("zero_op");
        end
    endtask

    task automatic test_backpressure();
        int sp0;
        core_delay = 3;
        sp0 = start_pulses;
        issue(16'd100, 16'd75);
        collect(16'd100, 16'd75, 3, 1'b0, sp0, "bp_first");
        in_a = 16'd7; in_b = 16'd14; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (in_ready !== 1'b0 || res_valid !== 1'b1 || res_gcd !== 16'd25 || res_err !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold cycle %0d: in_ready=%b res_valid=%b res_gcd=%0d res_err=%b required 0 1 25 0",
                         i, in_ready, res_valid, res_gcd, res_err);
            end
        end
        sp0 = start_pulses;
        drain("bp_drain");
        @(posedge clk); #1;
        in_valid = 1'b0;
        collect(16'd7, 16'd14, 3, 1'b0, sp0, "bp_second");
        drain("bp_second");
    endtask

    task automatic test_reset_mid();
        core_delay = 40;
        issue(16'd60, 16'd45);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (res_valid !== 1'b0 || core_clr !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_in_wait: res_valid=%b core_clr=%b in_ready=%b busy=%b required 0 1 0 1",
                     res_valid, core_clr, in_ready, busy);
        end
        rst = 1'b0;
        check_clear_run("rst_in_wait");
        // A buffered result is dropped by reset.
        issue(16'd0, 16'd9);
        @(posedge clk); #1;
        n_cmp++;
        if (res_valid !== 1'b1 || res_gcd !== 16'd9) begin
            n_fail++;
            $display("FAIL rst_buffered_setup: res_valid=%b res_gcd=%0d required 1 9", res_valid, res_gcd);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (res_valid !== 1'b0 || res_gcd !== '0) begin
            n_fail++;
            $display("FAIL rst_buffered_drop: res_valid=%b res_gcd=%0d required 0 0", res_valid, res_gcd);
        end
        rst = 1'b0;
        check_clear_run("rst_buffered");
    endtask

`ifdef GCD_SEQ_TIMEOUT_EN
    task automatic test_timeout();
        int sp0;
        core_never = 1'b1;
        sp0 = start_pulses;
        issue(16'd30, 16'd12);
        collect(16'd30, 16'd12, 0, 1'b1, sp0, "timeout");
        drain("timeout");
        core_never = 1'b0;
    endtask
`endif

    task automatic test_random_back_to_back();
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        int d;
        int sp0;
        for (int i = 0; i < 25; i++) begin
            a = ($urandom_range(0, 7) == 0) ? '0 : WIDTH'($urandom_range(1, 600));
            b = ($urandom_range(0, 7) == 0) ? '0 : WIDTH'($urandom_range(1, 600));
            d = $urandom_range(1, 8);
            core_delay = d;
            sp0 = start_pulses;
            issue(a, b);
            collect(a, b, d, 1'b0, sp0, "random");
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            drain("random");
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_operands();
        test_backpressure();
        test_reset_mid();
`ifdef GCD_SEQ_TIMEOUT_EN
        test_timeout();
`endif
        test_random_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
